window_builder: RTL

- Producer side of the 108-bit 3x3 neighbourhood bus consumed by the per-pixel effect filters.
- Takes a raster-order RGB444 pixel stream, buffers two lines, and emits one packed 3x3 window per image pixel.
- Out-of-image neighbours are zero. Exactly IMG_WIDTH*IMG_HEIGHT windows are emitted per frame, including an end-of-frame flush.

---
 rtl/window_pkg.sv | 24 ++
 rtl/window_builder_line_buffer.sv | 48 ++++
 rtl/window_builder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/window_pkg.sv
// Shared constants and types for the 3x3 neighbourhood window bus.
package window_pkg;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned WIN_W = 9 * PIX_W;

    // Field placement inside the 108-bit window, from MSB down
    localparam int unsigned ORIG_LSB  = 96;
    localparam int unsigned LEFT_LSB  = 84;
    localparam int unsigned RIGHT_LSB = 72;
    localparam int unsigned UP_LSB    = 60;
    localparam int unsigned DOWN_LSB  = 48;
    localparam int unsigned UL_LSB    = 36;
    localparam int unsigned UR_LSB    = 24;
    localparam int unsigned DL_LSB    = 12;
    localparam int unsigned DR_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/window_builder_line_buffer.sv
// One-line delay: RAM plus wrap-around address, advancing only on shift.
module line_buffer
    import window_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_d;

    // The slot about to be overwritten holds the sample from DEPTH shifts ago
    assign dout_c = mem_q[addr_q];

    // Wrap the address at DEPTH-1
    always_comb begin
        addr_d = addr_q + AW'(1);
        if (addr_q == AW'(DEPTH - 1)) begin
            addr_d = '0;
        end
    end

    // Address register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (shift_en_i) begin
            addr_q <= addr_d;
        end
    end

    // Storage array, contents need no reset
    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[addr_q] <= din_i;
        end
    end

endmodule

// File: rtl/window_builder.sv
// Builds one zero-masked 3x3 RGB444 window per pixel from a raster stream.
module window_builder
    import window_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              pix_in,
    input  logic                          pix_valid,
    input  logic                          pix_sof,
    output logic                          pix_ready,
    output logic [WIN_W-1:0]              color_data,
    output logic                          window_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
    output logic                          frame_done
);

    localparam int unsigned XW   = $clog2(IMG_WIDTH);
    localparam int unsigned YW   = $clog2(IMG_HEIGHT);
    localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned NW   = $clog2(NPIX);
    localparam int unsigned FW   = $clog2(IMG_WIDTH + 1);

    state_t           state_q, state_d;
    logic [NW-1:0]    n_q, n_d;
    logic [FW-1:0]    fc_q, fc_d;
    logic [XW-1:0]    cx_q, cx_d;
    logic [YW-1:0]    cy_q, cy_d;

    logic             shift_en_c;
    logic             emit_c;
    logic             restart_c;
    logic             last_c;

    logic [PIX_W-1:0] pix_sh_c;
    logic [PIX_W-1:0] lb1_out_c;
    logic [PIX_W-1:0] lb2_out_c;
    logic [WIN_W-1:0] win_d;

    // Two stored tap columns; the third (newest) column is the live input
    // column {lb2, lb1, pixel}, so the window is formed in the acceptance cycle.
    logic [PIX_W-1:0] top_q [2];
    logic [PIX_W-1:0] mid_q [2];
    logic [PIX_W-1:0] bot_q [2];

    logic             pix_ready_q;
    logic [WIN_W-1:0] color_data_q;
    logic             window_valid_q;
    logic [XW-1:0]    win_x_q;
    logic [YW-1:0]    win_y_q;
    logic             frame_done_q;

    assign pix_ready    = pix_ready_q;
    assign color_data   = color_data_q;
    assign window_valid = window_valid_q;
    assign win_x        = win_x_q;
    assign win_y        = win_y_q;
    assign frame_done   = frame_done_q;

    // Zeros are shifted in while flushing the last line
    assign pix_sh_c = (state_q == FLUSH) ? '0 : pix_in;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (shift_en_c),
        .din_i      (pix_sh_c),
        .dout_c     (lb1_out_c)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb2 (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (shift_en_c),
        .din_i      (lb1_out_c),
        .dout_c     (lb2_out_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pix_valid && pix_sof) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pix_valid && !pix_sof && (n_q == NW'(NPIX - 1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fc_q == FW'(IMG_WIDTH)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM control outputs: shift, window emit, frame restart, last window
    always_comb begin
        shift_en_c = 1'b0;
        emit_c     = 1'b0;
        restart_c  = 1'b0;
        last_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pix_valid && pix_sof) begin
                    shift_en_c = 1'b1;
                    restart_c  = 1'b1;
                end
            end
            RUN: begin
                if (pix_valid) begin
                    shift_en_c = 1'b1;
                    if (pix_sof) begin
                        restart_c = 1'b1;
                    end else begin
                        emit_c = (n_q >= NW'(IMG_WIDTH + 1));
                    end
                end
            end
            FLUSH: begin
                shift_en_c = 1'b1;
                emit_c     = 1'b1;
                last_c     = (fc_q == FW'(IMG_WIDTH));
            end
            default: ;
        endcase
    end

    // Pixel index, flush count and centre coordinate of the next window
    always_comb begin
        n_d  = n_q;
        fc_d = '0;
        cx_d = cx_q;
        cy_d = cy_q;
        if (restart_c) begin
            n_d  = NW'(1);
            cx_d = '0;
            cy_d = '0;
        end else if ((state_q == RUN) && shift_en_c) begin
            n_d = n_q + NW'(1);
        end
        if ((state_q == FLUSH) && !last_c) begin
            fc_d = fc_q + FW'(1);
        end
        if (emit_c) begin
            if (cx_q == XW'(IMG_WIDTH - 1)) begin
                cx_d = '0;
                cy_d = (cy_q == YW'(IMG_HEIGHT - 1)) ? '0 : cy_q + YW'(1);
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q  <= '0;
            fc_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            n_q  <= n_d;
            fc_q <= fc_d;
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    // Tap columns shift left on every accepted or flushed pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q[0] <= '0;
            top_q[1] <= '0;
            mid_q[0] <= '0;
            mid_q[1] <= '0;
            bot_q[0] <= '0;
            bot_q[1] <= '0;
        end else if (shift_en_c) begin
            top_q[1] <= top_q[0];
            mid_q[1] <= mid_q[0];
            bot_q[1] <= bot_q[0];
            top_q[0] <= lb2_out_c;
            mid_q[0] <= lb1_out_c;
            bot_q[0] <= pix_sh_c;
        end
    end

    // Pack and border-mask the window; masking removes pixels wrapped from adjacent lines
    always_comb begin
        logic m_up, m_dn, m_lf, m_rt;
        m_up  = (cy_q == '0);
        m_dn  = (cy_q == YW'(IMG_HEIGHT - 1));
        m_lf  = (cx_q == '0);
        m_rt  = (cx_q == XW'(IMG_WIDTH - 1));
        win_d = '0;
        win_d[ORIG_LSB  +: PIX_W] = mid_q[0];
        win_d[LEFT_LSB  +: PIX_W] = m_lf           ? '0 : mid_q[1];
        win_d[RIGHT_LSB +: PIX_W] = m_rt           ? '0 : lb1_out_c;
        win_d[UP_LSB    +: PIX_W] = m_up           ? '0 : top_q[0];
        win_d[DOWN_LSB  +: PIX_W] = m_dn           ? '0 : bot_q[0];
        win_d[UL_LSB    +: PIX_W] = (m_up || m_lf) ? '0 : top_q[1];
        win_d[UR_LSB    +: PIX_W] = (m_up || m_rt) ? '0 : lb2_out_c;
        win_d[DL_LSB    +: PIX_W] = (m_dn || m_lf) ? '0 : bot_q[1];
        win_d[DR_LSB    +: PIX_W] = (m_dn || m_rt) ? '0 : pix_sh_c;
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_ready_q    <= 1'b1;
            color_data_q   <= '0;
            window_valid_q <= 1'b0;
            win_x_q        <= '0;
            win_y_q        <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            pix_ready_q    <= (state_d != FLUSH);
            window_valid_q <= emit_c;
            frame_done_q   <= last_c;
            if (emit_c) begin
                color_data_q <= win_d;
                win_x_q      <= cx_q;
                win_y_q      <= cy_q;
            end
        end
    end

endmodule
